// File: rtl/proc_pkg.sv
// Shared fetch-stage types and constants: address/instruction widths,
// reset PC, bubble encoding, FSM states and the buffered {pc, inst} entry.
package proc_pkg;

  localparam int PC_W = 16;
  localparam int INST_W = 16;

  localparam logic [PC_W-1:0]   RESET_PC = 16'h0000;
  localparam logic [INST_W-1:0] NOP      = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Next sequential word address; wraps from all-ones to zero.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} entries. Clear wins over
// push and pop; the head entry is presented combinationally.
module fetch_fifo
  import proc_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic               head_valid,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  // Pointer and occupancy update; clear drops every entry at once.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok   = pop && (count_q != '0);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clock) begin
    // NOTE: storage is deliberately not reset; count_q alone decides what is valid.
    if (push && !clear) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues 1-cycle-latency reads to
// instruction memory, buffers responses so decode can stall, and flushes on a
// MEM-stage redirect.
module fetch_prefetch_unit
  import proc_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              id_ready,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   pc_calc,
  output logic              inst_valid,
  output logic [CNT_W-1:0]  buf_count
);

  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(DEPTH);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] fpc_q, fpc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            discard_q, discard_d;

  logic            issue, push, pop, head_valid;
  logic [CNT_W:0]  occupancy;
  fetch_entry_t    head, push_entry;

  // FSM next state, issue decision and fetch PC update. Redirect overrides
  // issue; a request only goes out if a buffer slot is reserved for it.
  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    discard_d  = 1'b0;

    pop       = head_valid & id_ready;
    push      = inflight_q & ~discard_q & ~redirect;
    occupancy = {1'b0, buf_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    issue     = (state_q != IDLE) && !redirect && (occupancy < DEPTH_V);

    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (redirect) state_d = FLUSH;
      FLUSH:   state_d = redirect ? FLUSH : RUN;
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      fpc_d     = redirect_pc;
      discard_d = inflight_q;
    end else if (issue) begin
      fpc_d      = pc_inc(fpc_q);
      req_pc_d   = fpc_q;
      inflight_d = 1'b1;
    end
  end

  // Fetch control registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      fpc_q      <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  assign push_entry = '{pc: req_pc_q, inst: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (buf_count)
  );

  // Memory port and decode-facing outputs; bubbles read as NOP with pc_calc 0.
  always_comb begin
    imem_req   = issue;
    imem_addr  = fpc_q;
    inst_valid = head_valid;
    inst       = head_valid ? head.inst : NOP;
    pc_calc    = head_valid ? pc_inc(head.pc) : '0;
  end

endmodule
